// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin burst arbiter driving a registered 4:1 data mux.
// Define RR_MUX_ARB_TIMEOUT_EN to build in the idle-owner burst watchdog.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requesters starting at ptr
// BURST | requester sel owns the mux until its last beat (or watchdog expiry)
module rr_mux_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             err_timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt, sel_nxt;
  logic [1:0]       winner, cand;
  logic             any_req;
  logic             accept, xfer;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;
  logic             timeout_hit;

  // Descending scan so the smallest offset from ptr is the final winner.
  always_comb begin
    winner  = ptr;
    cand    = ptr;
    any_req = |in_valid;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (in_valid[cand]) winner = cand;
    end
  end

  always_comb begin
    mux_data = in_data0;
    case (sel)
      2'd0: mux_data = in_data0;
      2'd1: mux_data = in_data1;
      2'd2: mux_data = in_data2;
      2'd3: mux_data = in_data3;
      default: mux_data = in_data0;
    endcase
    mux_last = in_last[sel];
  end

  assign accept   = (state == BURST) && (!out_valid || out_ready);
  assign in_ready = accept ? (4'b0001 << sel) : 4'b0000;
  assign xfer     = accept && in_valid[sel];
  assign grant    = (state == BURST) ? (4'b0001 << sel) : 4'b0000;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BURST;
          sel_nxt   = winner;
        end
      end
      BURST: begin
        if ((xfer && mux_last) || timeout_hit) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
    end
  end

  // Output register: a drain and a new beat in the same cycle keep out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= mux_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;

  assign timeout_hit = (state == BURST) && !in_valid[sel] && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (state != BURST || xfer || timeout_hit) begin
        wd_cnt <= '0;
      end else if (!in_valid[sel]) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
  assign err_timeout    = 1'b0;
`endif

endmodule
